// File: rtl/serializer_pkg.sv
// Shared types and defaults for the serial-in capture block.
package serializer_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic {IDLE, SHIFT} ser_state_e;

endpackage

// File: rtl/serializer_in.sv
// Serial-in / parallel-out capture: start_i marks the MSB of a WIDTH-bit frame.
// data_o is only written on the edge that samples the LSB, so a partially
// assembled word is never exposed.
module serializer_in
  import serializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             data_i,
  output logic [WIDTH-1:0] data_o
);

  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  // Next-state and datapath: data_i is only looked at on a start edge or
  // inside a frame, so X on the idle line cannot reach any state.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          sr_d    = {{(WIDTH-1){1'b0}}, data_i};
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // start_i is deliberately ignored here: no mid-word restart.
        sr_d  = {sr_q[WIDTH-2:0], data_i};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          dout_d  = {sr_q[WIDTH-2:0], data_i};
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset wins over everything and clears the output word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  assign data_o = dout_q;

endmodule

// File: tb/tb_serializer_in.sv
// Directed bench for serializer_in (WIDTH=8): hand-computed words, checked
// one time unit after each rising edge.
module tb_serializer_in;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic         data_i;
  logic [W-1:0] data_o;

  int n_chk  = 0;
  int n_fail = 0;

  serializer_in #(.WIDTH(W)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(start_i),
    .data_i (data_i),
    .data_o (data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One sampling edge with the given inputs; returns just after the edge.
  task automatic drive(input logic s, input logic d);
    @(negedge clk_i);
    start_i = s;
    data_i  = d;
    @(posedge clk_i);
    #1;
  endtask

  // Send a whole word MSB first. data_o must hold prev until the last edge,
  // then show w. restart_at >= 1 pulses start_i mid-frame (must be ignored).
  task automatic frame(input logic [W-1:0] w, input int restart_at, input logic [W-1:0] prev);
    for (int i = 0; i < W; i++) begin
      drive(i == 0 || i == restart_at, w[W-1-i]);
      if (i < W-1) chk("hold", data_o, prev);
      else         chk("word", data_o, w);
    end
  endtask

  initial begin
    rst_i   = 1'b1;
    start_i = 1'b0;
    data_i  = 1'b0;

    // 1. reset with random inputs
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      start_i = 1'($urandom);
      data_i  = 1'($urandom);
      @(posedge clk_i);
      #1;
      chk("reset", data_o, 8'h00);
    end
    @(negedge clk_i);
    rst_i   = 1'b0;
    start_i = 1'b0;

    // 2. single frame 1,0,1,1,0,0,1,0
    frame(8'hB2, -1, 8'h00);

    // 3. back-to-back frames, no gap
    frame(8'hA5, -1, 8'hB2);
    frame(8'h3C, -1, 8'hA5);

    // 4. start_i pulsed at bit 4 is ignored
    frame(8'hFF, 4, 8'h3C);

    // 5. reset mid-frame discards partial word and clears data_o
    frame(8'hC3, -1, 8'hFF);
    drive(1'b1, 1'b1);
    chk("partial0", data_o, 8'hC3);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    chk("partial3", data_o, 8'hC3);
    @(negedge clk_i);
    rst_i   = 1'b1;
    start_i = 1'b0;
    data_i  = 1'b1;
    @(posedge clk_i);
    #1;
    chk("midrst", data_o, 8'h00);
    @(negedge clk_i);
    rst_i = 1'b0;
    frame(8'h81, -1, 8'h00);

    // 6. idle hold with toggling (and occasionally X) data_i
    frame(8'h5A, -1, 8'h81);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, (i % 5 == 4) ? 1'bx : 1'(i & 1));
      chk("idle", data_o, 8'h5A);
    end
    // line idle garbage must not leak into the next word
    frame(8'h69, -1, 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
